// File: rtl/pulse_hold_fifo_if.sv
// Event bus between a code producer and pulse_hold_fifo.
//   sig_in   : event code from producer (0 = no event)
//   sig_out  : held event code toward the slow consumer
//   busy     : event queue full
//   overflow : one-cycle drop pulse   (only with PULSE_HOLD_OVF_EN)
//   drop_cnt : saturating drop count  (only with PULSE_HOLD_OVF_EN)
interface pulse_hold_fifo_if #(
  parameter int unsigned WIDTH = 3
);
  logic [WIDTH-1:0] sig_in;
  logic [WIDTH-1:0] sig_out;
  logic             busy;
`ifdef PULSE_HOLD_OVF_EN
  logic             overflow;
  logic [7:0]       drop_cnt;
`endif

  modport master (
    output sig_in,
    input  sig_out,
    input  busy
`ifdef PULSE_HOLD_OVF_EN
    ,
    input  overflow,
    input  drop_cnt
`endif
  );

  modport slave (
    input  sig_in,
    output sig_out,
    output busy
`ifdef PULSE_HOLD_OVF_EN
    ,
    output overflow,
    output drop_cnt
`endif
  );
endinterface

// File: rtl/pulse_hold_fifo.sv
// pulse_hold_fifo: queues every non-zero input code as one event and replays
// each event as a level held for HOLD_CYCLES cycles, followed by a forced
// zero gap of GAP_CYCLES cycles plus one idle cycle.
// Ports:
//   clk : block clock, rising edge
//   rst : asynchronous reset, active-low
//   bus : pulse_hold_fifo_if.slave (sig_in, sig_out, busy[, overflow, drop_cnt])
// Optional feature: define PULSE_HOLD_OVF_EN to build the overflow pulse and
// the saturating drop_cnt counter; without it drops are silent.
module pulse_hold_fifo #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES  = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  pulse_hold_fifo_if.slave     bus
);

  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned MAX_HG    = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_T     = (MAX_HG > 2) ? MAX_HG : 2;
  localparam int unsigned TMR_W     = $clog2(MAX_T);
  localparam int unsigned HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int unsigned GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [WIDTH-1:0] sig_out_q;
  logic             busy_q;

  logic             full_c;
  logic             event_c;
  logic             push_c;
  logic             pop_c;
  logic [CNT_W-1:0] count_nxt_c;

  // Push/pop qualification; a full queue drops even when a pop coincides.
  always_comb begin
    full_c  = (count == CNT_W'(DEPTH));
    event_c = |bus.sig_in;
    push_c  = event_c && !full_c;
    pop_c   = (state == S_IDLE) && (count != '0);
  end

  // Occupancy after this edge; busy is registered from it.
  always_comb begin
    count_nxt_c = count;
    if (push_c && !pop_c) begin
      count_nxt_c = count + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_nxt_c = count - CNT_W'(1);
    end
  end

  // Queue storage; contents need no reset since count gates all reads.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= bus.sig_in;
    end
  end

  // Queue pointers, occupancy and full flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy_q <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count  <= count_nxt_c;
      busy_q <= (count_nxt_c == CNT_W'(DEPTH));
    end
  end

  // Replay FSM: IDLE pops, HOLD drives the code, GAP forces zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      sig_out_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          sig_out_q <= '0;
          if (pop_c) begin
            sig_out_q <= mem[rd_ptr];
            timer     <= TMR_W'(HOLD_LOAD);
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (timer == '0) begin
            sig_out_q <= '0;
            if (GAP_CYCLES > 0) begin
              timer <= TMR_W'(GAP_LOAD);
              state <= S_GAP;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_GAP: begin
          sig_out_q <= '0;
          if (timer == '0) begin
            state <= S_IDLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: begin
          sig_out_q <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sig_out = sig_out_q;
  assign bus.busy    = busy_q;

`ifdef PULSE_HOLD_OVF_EN
  logic       overflow_q;
  logic [7:0] drop_cnt_q;

  // Drop reporting: pulse for one cycle, count saturates at 255.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= event_c && full_c;
      if (event_c && full_c && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign bus.overflow = overflow_q;
  assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pulse_hold_fifo.sv
// Bench for pulse_hold_fifo (WIDTH=3, DEPTH=4, HOLD=4, GAP=2). Accepted codes
// go into a scoreboard queue as they are driven; a cycle model releases them
// on its own hold/gap schedule and every cycle is compared against the DUT.
// Drop reporting is checked when PULSE_HOLD_OVF_EN is defined.
module tb_pulse_hold_fifo;

  localparam int unsigned W     = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned GAP   = 2;

  logic clk_a_tb = 1'b0;
  logic rst_n_tb;

  always #5 clk_a_tb = ~clk_a_tb;

  pulse_hold_fifo_if #(.WIDTH(W)) bus_if ();

  pulse_hold_fifo #(
    .WIDTH       (W),
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk (clk_a_tb),
    .rst (rst_n_tb),
    .bus (bus_if)
  );

  logic [W-1:0] exp_q [$];
  logic [W-1:0] exp_out;
  int           hold_rem;
  int           zero_rem;
  int           exp_drops;
  logic         exp_ovf;
  int           n_checks;
  int           n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_out   = '0;
    hold_rem  = 0;
    zero_rem  = 0;
    exp_drops = 0;
    exp_ovf   = 1'b0;
  endtask

  // Drive one code for one edge, advance the model, then compare.
  task automatic tick(input logic [W-1:0] code);
    int   s;
    logic drop;
    bus_if.sig_in = code;
    s    = exp_q.size();
    drop = (code != '0) && (s == int'(DEPTH));
    if (exp_out != '0) begin
      if (hold_rem > 0) begin
        hold_rem--;
      end else begin
        exp_out  = '0;
        zero_rem = int'(GAP);
      end
    end else if (zero_rem > 0) begin
      zero_rem--;
    end else if (s > 0) begin
      exp_out  = exp_q.pop_front();
      hold_rem = int'(HOLD) - 1;
    end
    if ((code != '0) && !drop) begin
      exp_q.push_back(code);
    end
    exp_ovf = drop;
    if (drop && exp_drops < 255) begin
      exp_drops++;
    end
    @(posedge clk_a_tb);
    #1;
    chk("sig_out", 32'(bus_if.sig_out), 32'(exp_out));
    chk("busy", 32'(bus_if.busy), 32'(exp_q.size() == int'(DEPTH)));
`ifdef PULSE_HOLD_OVF_EN
    chk("overflow", 32'(bus_if.overflow), 32'(exp_ovf));
    chk("drop_cnt", 32'(bus_if.drop_cnt), 32'(exp_drops));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick('0);
    end
  endtask

  // Assert reset mid-cycle, check asynchronous clearing, then release.
  task automatic async_reset();
    #2;
    rst_n_tb = 1'b0;
    #1;
    chk("rst_sig_out", 32'(bus_if.sig_out), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
`ifdef PULSE_HOLD_OVF_EN
    chk("rst_overflow", 32'(bus_if.overflow), 32'd0);
    chk("rst_drop_cnt", 32'(bus_if.drop_cnt), 32'd0);
`endif
    model_clear();
    rst_n_tb = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_clear();
    bus_if.sig_in = '0;
    rst_n_tb      = 1'b0;
    repeat (3) @(posedge clk_a_tb);
    #1;
    chk("reset_sig_out", 32'(bus_if.sig_out), 32'd0);
    chk("reset_busy", 32'(bus_if.busy), 32'd0);
    rst_n_tb = 1'b1;
    idle(2);

    // Single event
    tick(3'd6);
    idle(12);

    // Back-to-back events
    tick(3'd3);
    tick(3'd5);
    idle(20);

    // Fill and drop
    for (int i = 1; i <= 6; i++) begin
      tick(W'(i));
    end
`ifdef PULSE_HOLD_OVF_EN
    chk("fill_drop_cnt", 32'(bus_if.drop_cnt), 32'd1);
`endif
    idle(40);

    // Repeated identical code
    tick(3'd7);
    tick(3'd7);
    tick(3'd7);
    idle(25);

    // Reset in the second hold cycle with a second event queued
    tick(3'd2);
    tick(3'd4);
    tick(3'd0);
    async_reset();
    idle(20);

    // Reset while the queue is full
    for (int i = 1; i <= 5; i++) begin
      tick(W'(i));
    end
    chk("full_before_rst", 32'(bus_if.busy), 32'd1);
    async_reset();
    idle(10);

    // Saturation: keep the queue full and drop well over 255 events
    for (int i = 0; i < 360; i++) begin
      tick(W'((i % 7) + 1));
    end
`ifdef PULSE_HOLD_OVF_EN
    chk("sat_drop_cnt", 32'(bus_if.drop_cnt), 32'd255);
`endif
    idle(60);
    chk("drained_busy", 32'(bus_if.busy), 32'd0);
    chk("drained_sig_out", 32'(bus_if.sig_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_hold_fifo.md
# pulse_hold_fifo

Parametrised single-clock event stretcher for multi-bit control codes. Each non-zero input cycle is queued as one event. Each event is replayed on the output as a level held for a programmable number of cycles, followed by a forced zero gap, so a much slower consumer can sample every event. It generalises the 3-bit pulse synchroniser to any width, adds a queue of configurable depth instead of a single busy slot, and has programmable hold and gap lengths.

## Interface
- WIDTH, 3: code width in bits; value 0 means "no event".
- DEPTH, 4: event queue depth; power of two, ≥2.
- HOLD_CYCLES, 1000: cycles each event is held on sig_out; ≥1.
- GAP_CYCLES, 1000: extra zero cycles between consecutive events; ≥0.

Ports:
- clk  in  1  block clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- sig_in  in  WIDTH  event code; each cycle with sig_in≠0 is one event.
- sig_out  out  WIDTH  held event code; 0 when idle or in a gap.
- busy  out  1  queue full; registered, equals (count==DEPTH).
- overflow  out  1  one-cycle pulse when an event is dropped. Present only with PULSE_HOLD_OVF_EN.
- drop_cnt  out  8  saturating count of dropped events. Present only with PULSE_HOLD_OVF_EN.

## Operation
- Queue: circular FIFO of DEPTH×WIDTH entries, with pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count of $clog2(DEPTH)+1 bits.
- Push: on a clk edge with sig_in≠0 and count<DEPTH (count sampled before the edge).
  - sig_in≠0 while count==DEPTH: event dropped, queue unchanged. This holds even if a pop occurs on the same edge.
- Pop: performed only by the FSM in IDLE when count>0.
  - When push and pop happen on the same edge, count is unchanged.
- FSM states:
  - IDLE: sig_out=0. If count>0, pop the head, load sig_out with it, load timer=HOLD_CYCLES-1, go to HOLD.
  - HOLD: sig_out holds the code. If timer==0: sig_out←0; if GAP_CYCLES>0, timer←GAP_CYCLES-1 and go to GAP, else go to IDLE. Otherwise timer−1.
  - GAP: sig_out=0. If timer==0 go to IDLE, else timer−1.
- Timer width: $clog2(max(HOLD_CYCLES,GAP_CYCLES,2)).
- Consecutive identical codes are always separated by at least GAP_CYCLES+1 zero cycles, so they remain distinguishable.
- Reset (asserted at any time, including mid-hold):
  - sig_out=0, busy=0, count=0, pointers=0, state=IDLE, overflow=0, drop_cnt=0.
  - Queued events are discarded.

## Timing
- An event sampled on edge N (queue empty, FSM idle) is popped on edge N+1. sig_out shows it from edge N+1 for exactly HOLD_CYCLES cycles.
- Back-to-back throughput: one event per HOLD_CYCLES+GAP_CYCLES+1 cycles.
- Zero-cycle period between events: GAP_CYCLES+1, the extra cycle being IDLE.
- busy rises on the edge that makes count==DEPTH. It falls on the edge of the next pop that is not accompanied by a push.
- overflow pulses during the cycle after the edge that dropped the event.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- PULSE_HOLD_OVF_EN defined:
  - overflow and drop_cnt ports plus their logic are compiled in.
  - drop_cnt increments once per dropped event and saturates at 255.
- PULSE_HOLD_OVF_EN undefined:
  - Both ports and their logic are absent.
  - Drops are silent; all other behaviour is identical.

## Test plan
Bench parameters: WIDTH=3, DEPTH=4, HOLD_CYCLES=4, GAP_CYCLES=2, with PULSE_HOLD_OVF_EN defined.
- Single event:
  - Stimulus: rst released; sig_in=6 for one cycle (edge 0).
  - Required: sig_out=6 after edges 1–4, 0 after edge 5 onward; busy stays 0.
- Back-to-back events:
  - Stimulus: 3 on edge 0, 5 on edge 1.
  - Required: sig_out=3 for 4 cycles, then 0 for exactly 3 cycles, then 5 for 4 cycles.
- Fill and drop:
  - Stimulus: codes 1,2,3,4,5,6 on edges 0–5.
  - Required: busy=1 after edge 4; code 6 dropped; overflow pulses once; drop_cnt=1; output order 1,2,3,4,5 with no loss.
- Repeated identical code:
  - Stimulus: 7 on edges 0, 1, 2.
  - Required: three separate 4-cycle holds of 7, each pair separated by 3 zero cycles.
- Reset mid-hold:
  - Stimulus: after 2 queued events, assert rst during the second HOLD cycle.
  - Required: sig_out=0 and busy=0 immediately (asynchronously); after release, no further output until new input.
- Saturation:
  - Stimulus: hold the queue full and drop 300 events.
  - Required: drop_cnt ends at 255; the queued events still drain correctly.
